// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the fetch stage.
//   - icode constants I_HALT..I_POPQ
//   - REG_NONE register id used when an instruction has no register byte
//   - STAT_* status codes reported with each fetched instruction
//   - fetch_state_e : fetch FSM encoding (also exported on a debug port)
//   - ilen()        : instruction length in bytes, 0 for an invalid icode
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } fetch_state_e;

  // Length 0 marks an icode outside the instruction set.
  function automatic logic [3:0] ilen(input logic [3:0] icode);
    case (icode)
      I_HALT, I_NOP, I_RET:                 ilen = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:     ilen = 4'd2;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:         ilen = 4'd10;
      I_JXX, I_CALL:                        ilen = 4'd9;
      default:                              ilen = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_align.sv
// Combinational field extraction for a fetched instruction.
// Ports:
//   icode  in  4       instruction code (byte 0 high nibble)
//   ibytes in  72      instruction bytes 1..9, byte 1 in [7:0]
//   ra/rb  out 4       register ids, REG_NONE when no register byte
//   valc   out ADDR_W  little-endian constant, 0 when none
module fetch_align
  import y86_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [3:0]        icode,
  input  logic [71:0]       ibytes,
  output logic [3:0]        ra,
  output logic [3:0]        rb,
  output logic [ADDR_W-1:0] valc
);

  logic [63:0] const64;

  always_comb begin
    ra      = REG_NONE;
    rb      = REG_NONE;
    const64 = 64'd0;
    case (icode)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
        ra = ibytes[7:4];
        rb = ibytes[3:0];
      end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        ra      = ibytes[7:4];
        rb      = ibytes[3:0];
        const64 = ibytes[71:8];   // bytes 2..9
      end
      I_JXX, I_CALL: begin
        const64 = ibytes[63:0];   // bytes 1..8, no register byte
      end
      default: ;
    endcase
  end

  assign valc = const64[ADDR_W-1:0];

endmodule

// File: rtl/fetch_unit.sv
// Y86-64 fetch stage: accepts a PC, reads the instruction byte-serially from
// a byte-wide memory, and presents icode/ifun/rA/rB/valC/valP/stat until the
// consumer takes them.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1 (pc_valid/pc_ready, out_valid/out_ready); mem_req/mem_ack work the
// same way with mem_ack as the ready side, and mem_addr holds while mem_req=1.
// Ports:
//   pc_in/pc_valid/pc_ready        PC input; pc_ready only in IDLE
//   mem_req/mem_addr/mem_ack/...   one outstanding byte read at a time
//   icode..stat/out_valid/out_ready decoded result, held in DONE
//   dbg_state                      current FSM state
module fetch_unit
  import y86_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_err,
  output logic [3:0]        icode,
  output logic [3:0]        ifun,
  output logic [3:0]        rA,
  output logic [3:0]        rB,
  output logic [ADDR_W-1:0] valC,
  output logic [ADDR_W-1:0] valP,
  output logic [1:0]        stat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        dbg_state
);

  localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        byte_cnt_q, byte_cnt_d;
  logic [3:0]        len_q, len_d;
  logic [79:0]       ibuf_q, ibuf_d;
  logic [ADDR_W-1:0] valp_q, valp_d;
  logic [1:0]        stat_q, stat_d;
  logic [31:0]       wait_q, wait_d;
  logic [3:0]        cur_len;
  logic [6:0]        bit_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      mem_addr_q <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      ibuf_q     <= '0;
      valp_q     <= '0;
      stat_q     <= STAT_AOK;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      ibuf_q     <= ibuf_d;
      valp_q     <= valp_d;
      stat_q     <= stat_d;
      wait_q     <= wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    ibuf_d     = ibuf_q;
    valp_d     = valp_q;
    stat_d     = stat_q;
    wait_d     = wait_q;
    bit_idx    = {byte_cnt_q, 3'b000};
    // The length is only known once byte 0 arrives, so use it directly then.
    cur_len    = (byte_cnt_q == 4'd0) ? ilen(mem_rdata[7:4]) : len_q;

    case (state_q)
      S_IDLE: begin
        if (pc_valid) begin
          pc_d       = pc_in;
          mem_addr_d = pc_in;
          byte_cnt_d = '0;
          len_d      = '0;
          ibuf_d     = '0;
          valp_d     = '0;
          stat_d     = STAT_AOK;
          wait_d     = '0;
          state_d    = S_FETCH;
        end
      end

      S_FETCH: begin
        if (mem_ack) begin
          wait_d = '0;
          if (mem_err) begin
            stat_d  = STAT_ADR;
            state_d = S_DONE;
          end else begin
            ibuf_d[bit_idx +: 8] = mem_rdata;
            if (byte_cnt_q == 4'd0) begin
              len_d  = cur_len;
              valp_d = pc_q + ADDR_W'(cur_len);
            end
            if (cur_len == 4'd0) begin
              stat_d  = STAT_INS;
              state_d = S_DONE;
            end else if (byte_cnt_q == cur_len - 4'd1) begin
              state_d = S_DONE;
              // halt is the only 1-byte instruction that changes status
              if (byte_cnt_q == 4'd0 && mem_rdata[7:4] == I_HALT) begin
                stat_d = STAT_HLT;
              end
            end else begin
              byte_cnt_d = byte_cnt_q + 4'd1;
              mem_addr_d = mem_addr_q + ADDR_W'(1);
            end
          end
        end else if (TIMEOUT != 0 && wait_q == WAIT_LAST) begin
          stat_d  = STAT_ADR;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  fetch_align #(.ADDR_W(ADDR_W)) u_align (
    .icode  (ibuf_q[7:4]),
    .ibytes (ibuf_q[79:8]),
    .ra     (rA),
    .rb     (rB),
    .valc   (valC)
  );

  assign pc_ready  = (state_q == S_IDLE);
  assign mem_req   = (state_q == S_FETCH);
  assign out_valid = (state_q == S_DONE);
  assign mem_addr  = mem_addr_q;
  assign icode     = ibuf_q[7:4];
  assign ifun      = ibuf_q[3:0];
  assign valP      = valp_q;
  assign stat      = stat_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// instructions, all compared against a byte-level reference model.
module tb_fetch_unit;

  localparam int TO = 4;
  localparam logic [1:0] ST_AOK = 2'd0, ST_HLT = 2'd1, ST_ADR = 2'd2, ST_INS = 2'd3;

  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic [1:0]  stat;
    int          nreq;
    bit          fields;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  initial forever #5 clk = ~clk;

  logic [63:0] pc_in;
  logic        pc_valid, pc_ready;
  logic        mem_req, mem_ack, mem_err;
  logic [63:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic [1:0]  stat;
  logic        out_valid, out_ready;
  logic [1:0]  dbg_state;

  fetch_unit #(.ADDR_W(64), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_err(mem_err), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
    .valP(valP), .stat(stat), .out_valid(out_valid), .out_ready(out_ready),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory + responder ----------------
  logic [7:0]  mem [logic [63:0]];
  int          min_dly = 0, max_dly = 0, cur_dly = 0, wcnt = 0;
  int          err_idx = -1, ack_idx = 0, req_cycles = 0;
  bit          no_ack = 1'b0;
  logic [63:0] acked_q[$];

  function automatic logic [7:0] rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  initial begin : responder
    mem_ack = 1'b0; mem_rdata = 8'h00; mem_err = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        req_cycles++;
        if (!no_ack && wcnt >= cur_dly) begin
          mem_ack   = 1'b1;
          mem_rdata = rd(mem_addr);
          mem_err   = (ack_idx == err_idx);
          acked_q.push_back(mem_addr);
          ack_idx++;
          wcnt      = 0;
          cur_dly   = $urandom_range(max_dly, min_dly);
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 8'($urandom);
          mem_err   = 1'($urandom_range(1, 0));
          wcnt++;
        end
      end else begin
        // stray acks while no request is outstanding must be ignored
        mem_ack   = 1'($urandom_range(1, 0));
        mem_rdata = 8'($urandom);
        mem_err   = 1'($urandom_range(1, 0));
        wcnt      = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic exp_t model(input logic [63:0] pc);
    exp_t e;
    logic [7:0] b0, b1;
    int len, off;
    b0 = rd(pc);
    b1 = rd(pc + 64'd1);
    e.icode = b0[7:4]; e.ifun = b0[3:0];
    e.ra = 4'hF; e.rb = 4'hF; e.valc = 64'd0; e.fields = 1'b1;
    case (e.icode)
      4'h0, 4'h1, 4'h9:       len = 1;
      4'h2, 4'h6, 4'hA, 4'hB: len = 2;
      4'h3, 4'h4, 4'h5:       len = 10;
      4'h7, 4'h8:             len = 9;
      default:                len = 0;
    endcase
    if (len == 0) begin
      e.stat = ST_INS; e.nreq = 1; e.valp = 64'd0; e.fields = 1'b0;
    end else begin
      e.stat = (e.icode == 4'h0) ? ST_HLT : ST_AOK;
      e.nreq = len;
      e.valp = pc + 64'(len);
    end
    if (len >= 2 && e.icode != 4'h7 && e.icode != 4'h8) begin
      e.ra = b1[7:4]; e.rb = b1[3:0];
    end
    off = (len == 10) ? 2 : (len == 9) ? 1 : -1;
    if (off > 0)
      for (int k = 0; k < 8; k++)
        e.valc = e.valc | (64'(rd(pc + 64'(off + k))) << (8 * k));
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_mem(input logic [63:0] pc, input logic [7:0] b [10]);
    for (int i = 0; i < 10; i++) mem[pc + 64'(i)] = b[i];
  endtask

  task automatic cfg(input int lo, input int hi, input int eidx, input bit nack);
    min_dly = lo; max_dly = hi; cur_dly = $urandom_range(hi, lo);
    err_idx = eidx; no_ack = nack;
    acked_q.delete(); ack_idx = 0; req_cycles = 0;
  endtask

  task automatic start_fetch(input string tag, input logic [63:0] pc, output int lat);
    @(negedge clk);
    pc_in = pc; pc_valid = 1'b1;
    chk({tag, ".pc_ready"}, 64'(pc_ready), 64'd1);
    @(negedge clk);
    lat = 1;
    pc_valid = 1'($urandom_range(1, 0));
    pc_in = {$urandom, $urandom};
    while (out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
      pc_valid = 1'($urandom_range(1, 0));
      pc_in = {$urandom, $urandom};
    end
    pc_valid = 1'b0;
    chk({tag, ".done"}, 64'(out_valid), 64'd1);
  endtask

  task automatic check_result(input string tag, input logic [63:0] pc, input exp_t e);
    chk({tag, ".icode"}, 64'(icode), 64'(e.icode));
    chk({tag, ".stat"}, 64'(stat), 64'(e.stat));
    chk({tag, ".nreq"}, 64'(acked_q.size()), 64'(e.nreq));
    for (int i = 0; i < acked_q.size() && i < e.nreq; i++)
      chk($sformatf("%s.addr%0d", tag, i), acked_q[i], pc + 64'(i));
    if (e.fields) begin
      chk({tag, ".ifun"}, 64'(ifun), 64'(e.ifun));
      chk({tag, ".rA"}, 64'(rA), 64'(e.ra));
      chk({tag, ".rB"}, 64'(rB), 64'(e.rb));
      chk({tag, ".valC"}, valC, e.valc);
      chk({tag, ".valP"}, valP, e.valp);
    end
  endtask

  task automatic hold_release(input string tag, input int hold, input exp_t e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".hold_pc_ready"}, 64'(pc_ready), 64'd0);
      chk({tag, ".hold_mem_req"}, 64'(mem_req), 64'd0);
      chk({tag, ".hold_icode"}, 64'(icode), 64'(e.icode));
      chk({tag, ".hold_stat"}, 64'(stat), 64'(e.stat));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".rel_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".rel_pc_ready"}, 64'(pc_ready), 64'd1);
  endtask

  task automatic full_fetch(input string tag, input logic [63:0] pc, input int hold);
    exp_t e;
    int lat;
    e = model(pc);
    start_fetch(tag, pc, lat);
    check_result(tag, pc, e);
    hold_release(tag, hold, e);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : main
    logic [7:0] b [10];
    exp_t e;
    int lat;
    pc_in = '0; pc_valid = 1'b0; out_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst.mem_req", 64'(mem_req), 64'd0);
    chk("rst.mem_addr", mem_addr, 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.icode", 64'(icode), 64'd0);
    chk("rst.ifun", 64'(ifun), 64'd0);
    chk("rst.rA", 64'(rA), 64'hF);
    chk("rst.rB", 64'(rB), 64'hF);
    chk("rst.valC", valC, 64'd0);
    chk("rst.valP", valP, 64'd0);
    chk("rst.stat", 64'(stat), 64'(ST_AOK));
    rst_n = 1'b1;

    // 1: irmovq at 0, zero-wait memory
    b = '{8'h30, 8'hF3, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    set_mem(64'h0, b);
    cfg(0, 0, -1, 1'b0);
    e = model(64'h0);
    start_fetch("t1", 64'h0, lat);
    chk("t1.latency", 64'(lat), 64'd11);
    chk("t1.valC_abs", valC, 64'hA);
    chk("t1.valP_abs", valP, 64'hA);
    check_result("t1", 64'h0, e);
    hold_release("t1", 1, e);

    // 2: jXX at 0x100 with a 2-cycle ack delay on every byte
    b = '{8'h73, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55};
    set_mem(64'h100, b);
    cfg(2, 2, -1, 1'b0);
    e = model(64'h100);
    start_fetch("t2", 64'h100, lat);
    chk("t2.latency", 64'(lat), 64'd28);
    chk("t2.valC_abs", valC, 64'h200);
    chk("t2.valP_abs", valP, 64'h109);
    check_result("t2", 64'h100, e);
    hold_release("t2", 0, e);

    // 3: ret and halt
    mem[64'h40] = 8'h90;
    cfg(0, 0, -1, 1'b0);
    e = model(64'h40);
    start_fetch("t3ret", 64'h40, lat);
    chk("t3ret.latency", 64'(lat), 64'd2);
    chk("t3ret.valP_abs", valP, 64'h41);
    check_result("t3ret", 64'h40, e);
    hold_release("t3ret", 0, e);
    mem[64'h50] = 8'h00;
    cfg(0, 1, -1, 1'b0);
    full_fetch("t3hlt", 64'h50, 1);
    chk("t3hlt.req_after", 64'(req_cycles) <= 64'd2, 64'd1);

    // 4: invalid opcode, consumer stalls 5 cycles
    mem[64'h60] = 8'hC0;
    cfg(0, 0, -1, 1'b0);
    full_fetch("t4", 64'h60, 5);
    chk("t4.req_cycles", 64'(req_cycles), 64'd1);

    // 5a: rmmovq with a memory error on the third byte
    b = '{8'h40, 8'h12, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    set_mem(64'h80, b);
    cfg(0, 0, 2, 1'b0);
    start_fetch("t5err", 64'h80, lat);
    chk("t5err.stat", 64'(stat), 64'(ST_ADR));
    chk("t5err.nreq", 64'(acked_q.size()), 64'd3);
    chk("t5err.req_cycles", 64'(req_cycles), 64'd3);
    e.icode = 4'h4; e.stat = ST_ADR;
    hold_release("t5err", 2, e);

    // 5b: memory never answers
    cfg(0, 0, -1, 1'b1);
    start_fetch("t5to", 64'h90, lat);
    chk("t5to.stat", 64'(stat), 64'(ST_ADR));
    chk("t5to.latency", 64'(lat), 64'(TO + 1));
    chk("t5to.req_cycles", 64'(req_cycles), 64'(TO));
    chk("t5to.mem_req", 64'(mem_req), 64'd0);
    e.icode = 4'h0; e.stat = ST_ADR;
    hold_release("t5to", 2, e);

    // 6: reset while byte 5 of an irmovq is outstanding
    b = '{8'h30, 8'hF7, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    set_mem(64'h200, b);
    cfg(0, 0, -1, 1'b0);
    @(negedge clk);
    pc_in = 64'h200; pc_valid = 1'b1;
    @(negedge clk);
    pc_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6.rst_mem_req", 64'(mem_req), 64'd0);
    chk("t6.rst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    b = '{8'h30, 8'hF2, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00};
    set_mem(64'h20, b);
    cfg(0, 0, -1, 1'b0);
    full_fetch("t6", 64'h20, 0);

    // random instructions, delays and stalls
    for (int n = 0; n < 30; n++) begin
      logic [63:0] pc;
      logic [3:0] ic;
      pc = (n % 10 == 9) ? 64'hFFFF_FFFF_FFFF_FFF8 : {$urandom, $urandom};
      ic = ($urandom_range(7, 0) == 0) ? 4'($urandom_range(15, 12)) : 4'($urandom_range(11, 0));
      for (int i = 0; i < 10; i++) b[i] = 8'($urandom);
      b[0] = {ic, 4'($urandom)};
      set_mem(pc, b);
      cfg(0, $urandom_range(2, 0), -1, 1'b0);
      full_fetch($sformatf("rnd%0d", n), pc, $urandom_range(3, 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
